mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shared-memory arbiter and access sequencer for the CPU. Instruction fetch and data load/store share a single multi-cycle memory port. The block accepts one request at a time, arbitrates fairly under contention, and drives the memory for a fixed latency. It returns read data or a write acknowledgement with a one-cycle valid pulse, plus stall signals the CPU uses to freeze the PC and pipeline.

## Interface
- ADDR_W, 16, address width
- DATA_W, 16, data width
- MEM_LAT, 4, cycles from the mem_en cycle to the mem_rdata-valid cycle; legal range ≥1
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- hlt  in  1  halt; blocks new fetch grants
- if_req  in  1  instruction fetch request (read-only port)
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched word
- if_valid  out  1  one-cycle completion pulse for fetch
- if_stall  out  1  if_req & ~if_valid (combinational)
- d_req  in  1  data request
- d_wr  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data
- d_valid  out  1  one-cycle completion pulse for data
- d_stall  out  1  d_req & ~d_valid (combinational)
- mem_en  out  1  memory access strobe, exactly one cycle per access
- mem_wr  out  1  write qualifier, meaningful only with mem_en
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid exactly MEM_LAT cycles after mem_en
- busy  out  1  state != IDLE

## Operation
- States:
  - IDLE: sample requests.
  - ISSUE: mem_en high for one cycle.
  - WAIT: MEM_LAT cycles.
  - DONE: valid pulse for one cycle, then return to IDLE.
- IDLE grant:
  - Eligible requesters are d_req and (if_req & ~hlt).
  - One eligible requester: it wins.
  - Both eligible: the requester named by priority bit pri wins, and pri flips to the loser.
  - Uncontended grants leave pri unchanged.
  - pri resets to D.
- On grant, latch owner, address, wdata and wr. Fetch always latches wr=0. Go to ISSUE.
- mem_addr, mem_wdata and mem_wr hold the latched values from ISSUE through DONE.
- WAIT uses a down-counter of width clog2(MEM_LAT+1). The counter is loaded in ISSUE and exits WAIT after MEM_LAT cycles.
- mem_rdata is captured at the edge ending the last WAIT cycle:
  - Owner I: into if_rdata.
  - Owner D, load: into d_rdata.
  - Owner D, store: d_rdata is unchanged.
- DONE pulses the owner's valid for one cycle. The non-owner's valid stays 0.
- Requests are ignored in ISSUE, WAIT and DONE. A requester holds req until its valid pulse.
- A req still high in the IDLE cycle after DONE is a new request, so a requester that holds req gets back-to-back accesses.
- hlt is sampled only in IDLE:
  - It blocks new fetch grants only.
  - An in-flight fetch completes normally.
  - Data requests are still served.
- rdata outputs hold their last captured value until the next capture for that port.

## Timing
- Request seen in IDLE at cycle R:
  - mem_en at R+1.
  - mem_rdata sampled in cycle R+1+MEM_LAT.
  - valid at R+MEM_LAT+2.
  - IDLE again at R+MEM_LAT+3.
- With MEM_LAT=4: valid at R+6, 7 cycles per access. MEM_LAT=1 gives valid at R+3.
- Reset (rst_n low at a rising edge), from any state:
  - Next cycle: state IDLE, pri=D, counter 0.
  - mem_en=0, mem_wr=0, mem_addr=0, mem_wdata=0.
  - if_valid=0, d_valid=0, if_rdata=0, d_rdata=0, busy=0.
  - An in-flight access is abandoned with no valid pulse, and late mem_rdata is ignored.
- Reset dominates simultaneous requests. The first grant is possible in the first cycle with rst_n high.
- Stall outputs are combinational on req and the registered valid. if_stall/d_stall are 0 in the valid cycle.

## Test plan
- Fetch read, MEM_LAT=4, memory returns 0xBEEF for if_addr=0x0010 → mem_en with mem_addr=0x0010 at R+1; if_valid=1 and if_rdata=0xBEEF at R+6; if_stall high during R..R+5.
- Store 0x1234 to 0x0040, then load 0x0040 → mem_wr=1 with mem_wdata=0x1234 on the first mem_en; d_valid at R+6 with d_rdata unchanged; the load returns 0x1234 with d_valid 7 cycles later.
- if_req and d_req both held high from reset → grant order D, I, D, I. Each valid is 7 cycles apart and mem_en never overlaps.
- hlt=1 with if_req held, then d_req pulsed → no fetch mem_en; data access served; after hlt=0, fetch granted in the next IDLE.
- rst_n low in the WAIT cycle of a load → next cycle all outputs zero and busy=0; no d_valid; a new request granted immediately after release.
- MEM_LAT=1 with back-to-back fetches, if_req held high → if_valid every 4 cycles; the address change is applied on the next grant.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch and data access,
// alternating winners under contention and pulsing a one-cycle valid on completion.
module mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hlt,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              d_stall,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  // state | meaning
  // IDLE  | sample requests, grant at most one
  // ISSUE | mem_en high for one cycle, load wait counter
  // WAIT  | count MEM_LAT cycles, capture mem_rdata on the last one
  // DONE  | owner's valid pulse, then back to IDLE
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pri_q, pri_d;
  logic              own_i_q, own_i_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              if_valid_q, if_valid_d;
  logic              d_valid_q, d_valid_d;

  logic elig_d, elig_i, pick_i;

  assign elig_d = d_req;
  assign elig_i = if_req & ~hlt;

  // pri_q names the port that wins the next contended grant (0 = data, 1 = fetch)
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pri_d       = pri_q;
    own_i_d     = own_i_q;
    mem_en_d    = 1'b0;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;
    pick_i      = 1'b0;
    case (state_q)
      IDLE: begin
        if (elig_d | elig_i) begin
          pick_i     = elig_i & (~elig_d | pri_q);
          if (elig_d & elig_i) pri_d = ~pri_q;
          own_i_d    = pick_i;
          mem_addr_d = pick_i ? if_addr : d_addr;
          mem_wr_d   = ~pick_i & d_wr;
          if (!pick_i) mem_wdata_d = d_wdata;
          mem_en_d   = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = CNT_W'(MEM_LAT);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = DONE;
          if (own_i_q) if_rdata_d = mem_rdata;
          else if (!mem_wr_q) d_rdata_d = mem_rdata;
          if_valid_d = own_i_q;
          d_valid_d  = ~own_i_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pri_q       <= 1'b0;
      own_i_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pri_q       <= pri_d;
      own_i_q     <= own_i_d;
      mem_en_q    <= mem_en_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_valid  = if_valid_q;
  assign d_valid   = d_valid_q;
  assign if_stall  = if_req & ~if_valid_q;
  assign d_stall   = d_req & ~d_valid_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (MEM_LAT 4 and 1) checked every cycle against a
// timeline model of each access, plus literal expectations for the directed scenarios.
module tb_mem_arbiter;
  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int LAT4 = 4;
  localparam int LAT1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          hlt [2];
  logic          if_req [2];
  logic [AW-1:0] if_addr [2];
  logic [DW-1:0] if_rdata [2];
  logic          if_valid [2];
  logic          if_stall [2];
  logic          d_req [2];
  logic          d_wr [2];
  logic [AW-1:0] d_addr [2];
  logic [DW-1:0] d_wdata [2];
  logic [DW-1:0] d_rdata [2];
  logic          d_valid [2];
  logic          d_stall [2];
  logic          mem_en [2];
  logic          mem_wr [2];
  logic [AW-1:0] mem_addr [2];
  logic [DW-1:0] mem_wdata [2];
  logic [DW-1:0] mem_rdata [2];
  logic          busy [2];

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .hlt(hlt[0]),
    .if_req(if_req[0]), .if_addr(if_addr[0]), .if_rdata(if_rdata[0]),
    .if_valid(if_valid[0]), .if_stall(if_stall[0]),
    .d_req(d_req[0]), .d_wr(d_wr[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
    .d_rdata(d_rdata[0]), .d_valid(d_valid[0]), .d_stall(d_stall[0]),
    .mem_en(mem_en[0]), .mem_wr(mem_wr[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .busy(busy[0])
  );

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .hlt(hlt[1]),
    .if_req(if_req[1]), .if_addr(if_addr[1]), .if_rdata(if_rdata[1]),
    .if_valid(if_valid[1]), .if_stall(if_stall[1]),
    .d_req(d_req[1]), .d_wr(d_wr[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
    .d_rdata(d_rdata[1]), .d_valid(d_valid[1]), .d_stall(d_stall[1]),
    .mem_en(mem_en[1]), .mem_wr(mem_wr[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .busy(busy[1])
  );

  int lat [2] = '{LAT4, LAT1};
  int cyc     = 0;
  int n_tests = 0;
  int n_fail  = 0;
  bit known   = 1'b0;
  bit rand_mode = 1'b0;
  int if_stall_cnt = 0;

  // model: ph = cycles since the grant cycle (0 = idle and able to grant)
  int            ph [2];
  bit            pri_i [2];
  bit            own_i [2];
  bit            fresh [2];
  logic [AW-1:0] m_addr [2];
  logic [DW-1:0] m_wdata [2];
  bit            m_wr [2];
  logic [DW-1:0] e_if [2];
  logic [DW-1:0] e_d [2];
  bit            keep_if [2];
  bit            keep_d [2];

  logic [DW-1:0] mem [int];
  logic [DW-1:0] rd_data [2];
  int            rd_due [2] = '{-1, -1};

  typedef struct {int k; int cyc; logic [AW-1:0] addr; logic wr; logic [DW-1:0] wdata;} en_t;
  typedef struct {int k; int cyc; bit is_if; logic [DW-1:0] data;} vl_t;
  en_t en_log [$];
  vl_t v_log [$];

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] cyc=%0d got=%h want=%h", name, k, cyc, act, exp);
    end
  endtask

  function automatic int key(input int k, input logic [AW-1:0] a);
    return k * 65536 + int'(a);
  endfunction

  function automatic logic [DW-1:0] mem_rd(input int k, input logic [AW-1:0] a);
    if (mem.exists(key(k, a))) return mem[key(k, a)];
    return a ^ 16'hA5A5;
  endfunction

  function automatic bit exp_v(input int k);
    return ph[k] == lat[k] + 2;
  endfunction

  function automatic int find_en(input int k, input int from, input int n);
    int seen = 0;
    foreach (en_log[i]) begin
      if (en_log[i].k == k && en_log[i].cyc >= from) begin
        if (seen == n) return i;
        seen++;
      end
    end
    return -1;
  endfunction

  function automatic int find_v(input int k, input int from, input int n);
    int seen = 0;
    foreach (v_log[i]) begin
      if (v_log[i].k == k && v_log[i].cyc >= from) begin
        if (seen == n) return i;
        seen++;
      end
    end
    return -1;
  endfunction

  task automatic chk_en(input string name, input int k, input int from, input int n, input int dcyc,
                        input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wdata);
    int i = find_en(k, from, n);
    chk({name, "_seen"}, k, i >= 0, 1'b1);
    if (i >= 0) begin
      chk({name, "_cyc"}, k, en_log[i].cyc - from, dcyc);
      chk({name, "_addr"}, k, en_log[i].addr, addr);
      chk({name, "_wr"}, k, en_log[i].wr, wr);
      if (wr) chk({name, "_wdata"}, k, en_log[i].wdata, wdata);
    end
  endtask

  task automatic chk_v(input string name, input int k, input int from, input int n, input int dcyc,
                       input bit is_if, input logic [DW-1:0] data);
    int i = find_v(k, from, n);
    chk({name, "_seen"}, k, i >= 0, 1'b1);
    if (i >= 0) begin
      chk({name, "_cyc"}, k, v_log[i].cyc - from, dcyc);
      chk({name, "_port"}, k, v_log[i].is_if, is_if);
      chk({name, "_data"}, k, v_log[i].data, data);
    end
  endtask

  // One cycle, entered at the falling edge: check, drive, memory, advance model.
  task automatic step();
    for (int k = 0; k < 2; k++) begin
      if (known) begin
        chk("busy", k, busy[k], ph[k] != 0);
        chk("mem_en", k, mem_en[k], ph[k] == 1);
        chk("if_valid", k, if_valid[k], exp_v(k) && own_i[k]);
        chk("d_valid", k, d_valid[k], exp_v(k) && !own_i[k]);
        chk("if_rdata", k, if_rdata[k], e_if[k]);
        chk("d_rdata", k, d_rdata[k], e_d[k]);
        if (ph[k] != 0 || fresh[k]) begin
          chk("mem_addr", k, mem_addr[k], m_addr[k]);
          chk("mem_wr", k, mem_wr[k], m_wr[k]);
          if (fresh[k] || m_wr[k]) chk("mem_wdata", k, mem_wdata[k], m_wdata[k]);
        end
      end
      if (mem_en[k] === 1'b1) begin
        en_t e;
        e.k = k; e.cyc = cyc; e.addr = mem_addr[k]; e.wr = mem_wr[k]; e.wdata = mem_wdata[k];
        en_log.push_back(e);
      end
      if (if_valid[k] === 1'b1 || d_valid[k] === 1'b1) begin
        vl_t v;
        v.k = k; v.cyc = cyc; v.is_if = (if_valid[k] === 1'b1);
        v.data = v.is_if ? if_rdata[k] : d_rdata[k];
        v_log.push_back(v);
      end
    end

    for (int k = 0; k < 2; k++) begin
      if (rand_mode) begin
        if (exp_v(k) && own_i[k]) begin
          if_req[k]  = 1'($urandom_range(0, 1));
          if_addr[k] = AW'($urandom_range(0, 31));
        end else if (!if_req[k] && $urandom_range(0, 3) == 0) begin
          if_req[k]  = 1'b1;
          if_addr[k] = AW'($urandom_range(0, 31));
        end
        if ((exp_v(k) && !own_i[k]) || (!d_req[k] && $urandom_range(0, 3) == 0)) begin
          d_req[k]   = (exp_v(k) && !own_i[k]) ? 1'($urandom_range(0, 1)) : 1'b1;
          d_wr[k]    = 1'($urandom_range(0, 1));
          d_addr[k]  = AW'($urandom_range(0, 15));
          d_wdata[k] = DW'($urandom);
        end
        if ($urandom_range(0, 15) == 0) hlt[k] = ~hlt[k];
      end else begin
        if (exp_v(k) && own_i[k] && !keep_if[k]) if_req[k] = 1'b0;
        if (exp_v(k) && !own_i[k] && !keep_d[k]) d_req[k] = 1'b0;
      end
    end
    if (rand_mode) rst_n = ($urandom_range(0, 399) != 0);

    #1;
    for (int k = 0; k < 2; k++) begin
      if (known) begin
        chk("if_stall", k, if_stall[k], if_req[k] && !(exp_v(k) && own_i[k]));
        chk("d_stall", k, d_stall[k], d_req[k] && !(exp_v(k) && !own_i[k]));
      end
    end
    if (if_stall[0] === 1'b1) if_stall_cnt++;

    for (int k = 0; k < 2; k++) begin
      mem_rdata[k] = (rd_due[k] == cyc) ? rd_data[k] : DW'($urandom);
      if (mem_en[k] === 1'b1) begin
        if (mem_wr[k] === 1'b1) mem[key(k, mem_addr[k])] = mem_wdata[k];
        else begin
          rd_data[k] = mem_rd(k, mem_addr[k]);
          rd_due[k]  = cyc + lat[k];
        end
      end
    end

    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        ph[k] = 0; pri_i[k] = 1'b0; own_i[k] = 1'b0; fresh[k] = 1'b1;
        m_addr[k] = '0; m_wdata[k] = '0; m_wr[k] = 1'b0; e_if[k] = '0; e_d[k] = '0;
      end else if (ph[k] == 0) begin
        bit ed = d_req[k];
        bit ei = if_req[k] && !hlt[k];
        if (ed || ei) begin
          bit win_i = (ed && ei) ? pri_i[k] : ei;
          if (ed && ei) pri_i[k] = !win_i;
          own_i[k] = win_i;
          fresh[k] = 1'b0;
          m_addr[k] = win_i ? if_addr[k] : d_addr[k];
          m_wr[k] = !win_i && d_wr[k];
          if (!win_i) m_wdata[k] = d_wdata[k];
          ph[k] = 1;
        end
      end else if (ph[k] == lat[k] + 1) begin
        if (own_i[k]) e_if[k] = mem_rdata[k];
        else if (!m_wr[k]) e_d[k] = mem_rdata[k];
        ph[k]++;
      end else if (ph[k] == lat[k] + 2) begin
        ph[k] = 0;
      end else begin
        ph[k]++;
      end
    end
    if (!rst_n) known = 1'b1;
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    int r;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      hlt[k] = 1'b0; if_req[k] = 1'b0; if_addr[k] = '0; d_req[k] = 1'b0; d_wr[k] = 1'b0;
      d_addr[k] = '0; d_wdata[k] = '0; mem_rdata[k] = '0; keep_if[k] = 1'b0; keep_d[k] = 1'b0;
    end
    @(negedge clk);
    step();
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_busy", k, busy[k], 1'b0);
      chk("rst_mem_en", k, mem_en[k], 1'b0);
      chk("rst_mem_addr", k, mem_addr[k], 16'h0000);
      chk("rst_if_rdata", k, if_rdata[k], 16'h0000);
      chk("rst_d_valid", k, d_valid[k], 1'b0);
    end

    // fetch read of 0x0010 returning 0xBEEF
    mem[key(0, 16'h0010)] = 16'hBEEF;
    if_stall_cnt = 0;
    r = cyc; if_req[0] = 1'b1; if_addr[0] = 16'h0010;
    repeat (8) step();
    chk_en("fetch_en", 0, r, 0, 1, 16'h0010, 1'b0, 16'h0000);
    chk_v("fetch_v", 0, r, 0, 6, 1'b1, 16'hBEEF);
    chk("fetch_stall_cycles", 0, if_stall_cnt, 6);

    // store 0x1234 to 0x0040, then load it back with req held
    r = cyc; d_req[0] = 1'b1; d_wr[0] = 1'b1; d_addr[0] = 16'h0040; d_wdata[0] = 16'h1234;
    keep_d[0] = 1'b1;
    repeat (2) step();
    d_wr[0] = 1'b0; d_wdata[0] = 16'h0000;
    repeat (11) step();
    keep_d[0] = 1'b0;
    repeat (2) step();
    chk_en("store_en", 0, r, 0, 1, 16'h0040, 1'b1, 16'h1234);
    chk_v("store_v", 0, r, 0, 6, 1'b0, 16'h0000);
    chk_en("load_en", 0, r, 1, 8, 16'h0040, 1'b0, 16'h0000);
    chk_v("load_v", 0, r, 1, 13, 1'b0, 16'h1234);

    // contention from reset: D, I, D, I
    rst_n = 1'b0; step(); rst_n = 1'b1;
    r = cyc;
    if_req[0] = 1'b1; if_addr[0] = 16'h0100; d_req[0] = 1'b1; d_wr[0] = 1'b0; d_addr[0] = 16'h0200;
    keep_if[0] = 1'b1; keep_d[0] = 1'b1;
    repeat (20) step();
    keep_if[0] = 1'b0; keep_d[0] = 1'b0;
    repeat (8) step();
    for (int n = 0; n < 4; n++) begin
      chk_en("arb_en", 0, r, n, 1 + 7 * n, (n % 2 == 1) ? 16'h0100 : 16'h0200, 1'b0, 16'h0000);
      chk_v("arb_v", 0, r, n, 6 + 7 * n, n % 2 == 1,
            (n % 2 == 1) ? (16'h0100 ^ 16'hA5A5) : (16'h0200 ^ 16'hA5A5));
    end

    // halt blocks fetch but data is served; fetch follows release of hlt
    r = cyc; hlt[0] = 1'b1;
    if_req[0] = 1'b1; if_addr[0] = 16'h0300; keep_if[0] = 1'b1;
    d_req[0] = 1'b1; d_wr[0] = 1'b0; d_addr[0] = 16'h0040;
    repeat (10) step();
    hlt[0] = 1'b0; keep_if[0] = 1'b0;
    repeat (8) step();
    chk_en("hlt_d_en", 0, r, 0, 1, 16'h0040, 1'b0, 16'h0000);
    chk_en("hlt_if_en", 0, r, 1, 11, 16'h0300, 1'b0, 16'h0000);
    chk_v("hlt_d_v", 0, r, 0, 6, 1'b0, 16'h1234);
    chk_v("hlt_if_v", 0, r, 1, 16, 1'b1, 16'hA6A5);

    // reset during WAIT of a load abandons it; held request is re-granted
    r = cyc; d_req[0] = 1'b1; d_wr[0] = 1'b0; d_addr[0] = 16'h0040;
    repeat (3) step();
    rst_n = 1'b0; step(); rst_n = 1'b1;
    chk("wrst_busy", 0, busy[0], 1'b0);
    chk("wrst_mem_en", 0, mem_en[0], 1'b0);
    chk("wrst_mem_addr", 0, mem_addr[0], 16'h0000);
    chk("wrst_d_valid", 0, d_valid[0], 1'b0);
    chk("wrst_d_rdata", 0, d_rdata[0], 16'h0000);
    chk("wrst_if_rdata", 0, if_rdata[0], 16'h0000);
    repeat (8) step();
    chk_en("wrst_regrant", 0, r, 1, 5, 16'h0040, 1'b0, 16'h0000);
    chk_v("wrst_v", 0, r, 0, 10, 1'b0, 16'h1234);

    // MEM_LAT=1 back-to-back fetches, address change lands on the next grant
    r = cyc; if_req[1] = 1'b1; if_addr[1] = 16'h0500; keep_if[1] = 1'b1;
    repeat (5) step();
    if_addr[1] = 16'h0600;
    repeat (6) step();
    keep_if[1] = 1'b0;
    repeat (2) step();
    for (int n = 0; n < 3; n++) begin
      chk_en("lat1_en", 1, r, n, 1 + 4 * n, (n < 2) ? 16'h0500 : 16'h0600, 1'b0, 16'h0000);
      chk_v("lat1_v", 1, r, n, 3 + 4 * n, 1'b1, (n < 2) ? 16'hA0A5 : 16'hA3A5);
    end

    rand_mode = 1'b1;
    repeat (3000) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
